float_div_issue: RTL and testbench
==================================

Name: float_div_issue

Overview:
- Sequential issue/capture stage placed directly in front of the combinational float_divide datapath.
- Accepts IEEE-754 single-precision operand pairs over a valid/ready handshake and registers them onto the divider inputs.
- Waits a programmable multicycle settle window for the long Newton-Raphson combinational chain, then captures the result and presents it over a valid/ready output handshake.
- Resolves IEEE special cases locally, because the divider only forces zero for zero operands.

Parameters:
- SETTLE_CYCLES, 4, number of clock cycles the divider inputs are held stable before div_result is sampled; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  32  dividend, IEEE-754 single.
- in_b  input  32  divisor, IEEE-754 single.
- div_a  output  32  registered dividend, drives float_divide A.
- div_b  output  32  registered divisor, drives float_divide B.
- div_result  input  32  float_divide div_result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  32  quotient.
- out_nan  output  1  result is NaN.
- out_inf  output  1  result is infinity.
- out_dbz  output  1  divide-by-zero, i.e. finite nonzero divided by zero.

Behaviour:
- Reset, applied asynchronously while rst=1:
  - state=IDLE.
  - div_a, div_b, out_data = 0.
  - out_valid, out_nan, out_inf, out_dbz = 0.
  - in_ready=1 once in IDLE.
- Reset mid-operation aborts the operation: no out_valid is produced and the pending result is discarded.
- in_ready = (state==IDLE), decoded combinationally from the state register. There is no operand overlap: one operation is in flight at a time.
- Operand classification is done on in_a/in_b at accept:
  - zero: exp==0. Denormals are flushed to zero.
  - inf: exp==FF, mant==0.
  - nan: exp==FF, mant!=0.
  - s = a[31]^b[31].
- Special-case results, in priority order:
  - (1) either NaN, or 0/0, or inf/inf -> 0x7FC00000 (sign 0), nan=1.
  - (2) nonzero finite / 0 -> {s,0x7F800000[30:0]}, inf=1, dbz=1.
  - (3) inf / finite -> {s,FF,0}, inf=1.
  - (4) finite / inf, or 0 / nonzero -> {s,31'b0}, no flags.
- FSM:
  - IDLE:
    - If in_valid, latch in_a->div_a and in_b->div_b.
    - Special case: load out_data and flags, go to DONE.
    - Otherwise: cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE:
    - div_a/div_b are held constant.
    - If cnt==0: out_data<=div_result, all flags 0, go to DONE.
    - Otherwise cnt<=cnt-1.
  - DONE:
    - out_valid=1; out_data and flags are held stable.
    - If out_ready, go to IDLE; out_valid drops the next cycle.
- Latency, with the accept edge as cycle 0:
  - Normal operand pair: out_valid high from cycle SETTLE_CYCLES+1.
  - Special case: out_valid high from cycle 1.
- Throughput: the best case is one operation per SETTLE_CYCLES+2 cycles when out_ready is tied high.
- out_ready asserted while out_valid=0 is ignored.
- in_valid asserted outside IDLE is ignored: not captured and not counted.
- cnt is 8 bits wide. It never wraps, because it is loaded only in IDLE and decrements only when nonzero.
- div_a/div_b keep the last operands after completion; the consumer must not rely on their value while IDLE.
- Normal-path arithmetic accuracy is that of the divider: result within 2 ulp of the true quotient. The stage itself performs no arithmetic on div_result.

Test Plan:
- Normal divide, SETTLE_CYCLES=4: in_a=0x40C00000 (6.0), in_b=0x40000000 (2.0) -> out_valid at cycle 5, out_data within 2 ulp of 0x40400000, all flags 0.
- Divide by zero: in_a=0xBF800000 (-1.0), in_b=0x00000000 -> out_valid at cycle 1, out_data=0xFF800000, out_inf=1, out_dbz=1.
- NaN cases, each giving out_data=0x7FC00000 with out_nan=1 at cycle 1:
  - 0x00000000 / 0x80000000.
  - 0x7F800000 / 0x7F800000.
  - 0x7FC00001 / 0x3F800000.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data and flags are stable, in_ready=0, and an in_valid pulse in that window is ignored. Then raise out_ready -> one transfer, and in_ready=1 on the next cycle.
- Reset mid-SETTLE: accept 0x41200000/0x40A00000, assert rst at cycle 2 -> outputs return to 0 asynchronously, no out_valid, and the next operation runs normally.
- Back-to-back operations with out_ready=1:
  - Issue 1.0/4.0, then 3.0/0x7F800000.
  - Expected results: ~0x3E800000, then 0x00000000.
  - Issue spacing of 6 cycles for the normal operation and 2 cycles for the special operation.

Source files
------------

// File: rtl/float_div_issue_if.sv
// ============================================================================
// Module  : float_div_issue_if
// Brief   : Handshake and divider-facing bundle for the float_div_issue stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface float_div_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_nan;
  logic        out_inf;
  logic        out_dbz;

  // Issue stage side
  modport slave (
    input  in_valid, in_a, in_b, div_result, out_ready,
    output in_ready, div_a, div_b, out_valid, out_data, out_nan, out_inf, out_dbz
  );

  // Producer / consumer / divider side
  modport master (
    output in_valid, in_a, in_b, div_result, out_ready,
    input  in_ready, div_a, div_b, out_valid, out_data, out_nan, out_inf, out_dbz
  );
endinterface

`default_nettype wire

// File: rtl/float_div_issue.sv
// ============================================================================
// Module  : float_div_issue
// Brief   : Issue/capture stage in front of a multicycle combinational divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

module float_div_issue #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  float_div_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0]  CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] div_a_q;
  logic [31:0] div_b_q;
  logic [31:0] out_data_q;
  logic        out_valid_q;
  logic        out_nan_q;
  logic        out_inf_q;
  logic        out_dbz_q;

  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;
  logic        sgn;
  logic        spc_d;
  logic [31:0] spc_data_d;
  logic        spc_nan_d, spc_inf_d, spc_dbz_d;

  // Denormals classify as zero, so they never reach the divider.
  assign a_zero = (bus.in_a[30:23] == 8'h00);
  assign a_inf  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] == 23'd0);
  assign a_nan  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] != 23'd0);
  assign b_zero = (bus.in_b[30:23] == 8'h00);
  assign b_inf  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] == 23'd0);
  assign b_nan  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] != 23'd0);
  assign sgn    = bus.in_a[31] ^ bus.in_b[31];

  always_comb begin
    spc_d      = 1'b1;
    spc_data_d = 32'd0;
    spc_nan_d  = 1'b0;
    spc_inf_d  = 1'b0;
    spc_dbz_d  = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spc_data_d = QNAN;
      spc_nan_d  = 1'b1;
    end else if (!a_zero && !a_inf && b_zero) begin
      spc_data_d = {sgn, 8'hFF, 23'd0};
      spc_inf_d  = 1'b1;
      spc_dbz_d  = 1'b1;
    end else if (a_inf) begin
      spc_data_d = {sgn, 8'hFF, 23'd0};
      spc_inf_d  = 1'b1;
    end else if (b_inf || a_zero) begin
      spc_data_d = {sgn, 31'd0};
    end else begin
      spc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      div_a_q     <= 32'd0;
      div_b_q     <= 32'd0;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_nan_q   <= 1'b0;
      out_inf_q   <= 1'b0;
      out_dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            div_a_q <= bus.in_a;
            div_b_q <= bus.in_b;
            if (spc_d) begin
              out_data_q  <= spc_data_d;
              out_nan_q   <= spc_nan_d;
              out_inf_q   <= spc_inf_d;
              out_dbz_q   <= spc_dbz_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // div_a/div_b have been stable SETTLE_CYCLES cycles when cnt reaches 0.
          if (cnt_q == 8'd0) begin
            out_data_q  <= bus.div_result;
            out_nan_q   <= 1'b0;
            out_inf_q   <= 1'b0;
            out_dbz_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_nan   = out_nan_q;
  assign bus.out_inf   = out_inf_q;
  assign bus.out_dbz   = out_dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_float_div_issue.sv
// ============================================================================
// Module  : tb_float_div_issue
// Brief   : Self-checking bench for float_div_issue with a divider model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_float_div_issue;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  float_div_issue_if bus();

  float_div_issue #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum {K_ZERO, K_INF, K_NAN, K_FIN} kind_t;
  typedef struct packed {
    logic        sp;
    logic [31:0] data;
    logic        nan;
    logic        inf;
    logic        dbz;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic rnd_ready = 1'b0;

  // Behavioural expectations
  logic        pending = 1'b0;
  logic        ev = 1'b0;
  int          m_rise = 0;
  res_t        m_res;
  logic [31:0] m_a, m_b;
  int          acc_count = 0;
  int          acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got nothing expected event (cycle %0d)", name, cyc);
  endtask

  function automatic kind_t kind_of(input logic [31:0] x);
    if (x[30:23] == 8'h00) return K_ZERO;
    if (x[30:23] != 8'hFF) return K_FIN;
    if (x[22:0] == 23'd0)  return K_INF;
    return K_NAN;
  endfunction

  function automatic logic [63:0] to_dbl(input logic [31:0] x);
    logic [10:0] ed;
    ed = 11'(x[30:23]) + 11'd896;
    return {x[31], ed, x[22:0], 29'd0};
  endfunction

  // The divider: true quotient for normal operands, truncated to single.
  function automatic logic [31:0] divq(input logic [31:0] a, input logic [31:0] b);
    real q;
    logic [63:0] qb;
    int e;
    if (kind_of(a) != K_FIN || kind_of(b) != K_FIN) return 32'h0BAD_F00D;
    q  = $bitstoreal(to_dbl(a)) / $bitstoreal(to_dbl(b));
    qb = $realtobits(q);
    e  = int'(qb[62:52]) - 896;
    if (e < 1 || e > 254) return 32'h0BAD_F00D;
    return {qb[63], e[7:0], qb[51:29]};
  endfunction

  function automatic res_t ref_result(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    kind_t ka, kb;
    logic s;
    ka = kind_of(a);
    kb = kind_of(b);
    s  = a[31] ^ b[31];
    r  = '{sp: 1'b1, data: 32'd0, nan: 1'b0, inf: 1'b0, dbz: 1'b0};
    if (ka == K_NAN || kb == K_NAN || (ka == kb && (ka == K_ZERO || ka == K_INF))) begin
      r.data = 32'h7FC0_0000;
      r.nan  = 1'b1;
    end else if (kb == K_ZERO) begin
      r.data = {s, 8'hFF, 23'd0};
      r.inf  = 1'b1;
      r.dbz  = (ka == K_FIN);
    end else if (ka == K_INF) begin
      r.data = {s, 8'hFF, 23'd0};
      r.inf  = 1'b1;
    end else if (kb == K_INF || ka == K_ZERO) begin
      r.data = {s, 31'd0};
    end else begin
      r.sp   = 1'b0;
      r.data = divq(a, b);
    end
    return r;
  endfunction

  // Divider model: only a value held SETTLE cycles yields the real quotient.
  int age = 0;
  logic [31:0] la = 32'd0, lb = 32'd0;
  always @(negedge clk) begin
    if (bus.div_a !== la || bus.div_b !== lb) age = 1;
    else if (age < 1000) age++;
    la = bus.div_a;
    lb = bus.div_b;
    bus.div_result = (age >= SETTLE) ? divq(la, lb) : (32'hDEAD_0000 ^ la ^ {lb[15:0], lb[31:16]});
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending = 1'b0;
      ev      = 1'b0;
    end else begin
      cyc++;
      if (pending && ev && bus.out_ready) begin
        pending = 1'b0;
      end else if (!pending && bus.in_valid) begin
        pending = 1'b1;
        m_a     = bus.in_a;
        m_b     = bus.in_b;
        m_res   = ref_result(bus.in_a, bus.in_b);
        m_rise  = cyc + (m_res.sp ? 0 : SETTLE);
        acc_count++;
        acc_cyc = cyc;
      end
      ev = pending && (cyc >= m_rise);
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!pending));
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      if (ev) begin
        chk("out_data", bus.out_data, m_res.data);
        chk("out_nan", 32'(bus.out_nan), 32'(m_res.nan));
        chk("out_inf", 32'(bus.out_inf), 32'(m_res.inf));
        chk("out_dbz", 32'(bus.out_dbz), 32'(m_res.dbz));
      end
      if (pending) begin
        chk("div_a", bus.div_a, m_a);
        chk("div_b", bus.div_b, m_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n0;
    n0 = acc_count;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (acc_count != n0) break;
    end
    bus.in_valid = 1'b0;
    if (acc_count == n0) fail("issue");
  endtask

  // Returns the cycle number (accept edge = cycle 0) where out_valid is first seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 300) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) fail("wait_valid");
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (pending && i < 300) begin
      tick();
      i++;
    end
    if (pending) fail("wait_idle");
  endtask

  task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_data, input int tol,
                         input logic [2:0] exp_flags);
    int lat, d;
    issue(a, b);
    wait_valid(lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    d = int'(bus.out_data) - int'(exp_data);
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("FAIL %s data: got %h expected %h (+/-%0d ulp)", name, bus.out_data, exp_data, tol);
    end
    chk({name, " flags"}, 32'({bus.out_nan, bus.out_inf, bus.out_dbz}), 32'(exp_flags));
    bus.out_ready = 1'b1;
    wait_idle();
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    logic s;
    s = ($urandom_range(0, 1) == 1);
    case ($urandom_range(0, 9))
      0: return {s, 31'd0};
      1: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      2: return {s, 8'hFF, 23'd0};
      3: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      default: return {s, 8'($urandom_range(100, 150)), 23'($urandom_range(0, 32'h7FFFFF))};
    endcase
  endfunction

  initial begin
    #500000;
    fail("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e1, e2, e3, lat;
    logic [31:0] d0;
    logic [2:0]  f0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = 32'd0;
    bus.in_b = 32'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", bus.out_data, 32'd0);
    chk("rst div_a", bus.div_a, 32'd0);
    chk("rst div_b", bus.div_b, 32'd0);
    chk("rst flags", 32'({bus.out_nan, bus.out_inf, bus.out_dbz}), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Model pins
    chk("pin 6/2", ref_result(32'h40C00000, 32'h40000000).data, 32'h40400000);
    chk("pin 1/4", ref_result(32'h3F800000, 32'h40800000).data, 32'h3E800000);
    chk("pin 3/inf", ref_result(32'h40400000, 32'h7F800000).data, 32'h00000000);
    chk("pin inf/0 dbz", 32'(ref_result(32'h7F800000, 32'h0).dbz), 32'd0);

    run_lit("6/2", 32'h40C00000, 32'h40000000, SETTLE + 1, 32'h40400000, 2, 3'b000);
    run_lit("-1/0", 32'hBF800000, 32'h00000000, 1, 32'hFF800000, 0, 3'b011);
    run_lit("0/-0", 32'h00000000, 32'h80000000, 1, 32'h7FC00000, 0, 3'b100);
    run_lit("inf/inf", 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 0, 3'b100);
    run_lit("nan/1", 32'h7FC00001, 32'h3F800000, 1, 32'h7FC00000, 0, 3'b100);

    // Backpressure with an ignored in_valid pulse
    issue(32'h3FC00000, 32'h3F000000);
    wait_valid(lat);
    d0 = bus.out_data;
    f0 = {bus.out_nan, bus.out_inf, bus.out_dbz};
    chk("bp data", d0, 32'h40400000);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_a = 32'h3F800000;
        bus.in_b = 32'h00000000;
        bus.in_valid = 1'b1;
      end
      tick();
      bus.in_valid = 1'b0;
      chk("bp hold data", bus.out_data, d0);
      chk("bp hold flags", 32'({bus.out_nan, bus.out_inf, bus.out_dbz}), 32'(f0));
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp released valid", 32'(bus.out_valid), 32'd0);
    chk("bp released in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of the settle window
    issue(32'h41200000, 32'h40A00000);
    tick();
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid rst out_data", bus.out_data, 32'd0);
    chk("mid rst div_a", bus.div_a, 32'd0);
    chk("mid rst in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("in rst out_valid", 32'(bus.out_valid), 32'd0);
    end
    rst = 1'b0;
    run_lit("10/5", 32'h41200000, 32'h40A00000, SETTLE + 1, 32'h40000000, 2, 3'b000);

    // Back-to-back issue with out_ready tied high
    bus.out_ready = 1'b1;
    issue(32'h3F800000, 32'h40800000);
    e1 = acc_cyc;
    issue(32'h40400000, 32'h7F800000);
    e2 = acc_cyc;
    issue(32'h40000000, 32'h3F800000);
    e3 = acc_cyc;
    chk("spacing normal", 32'(e2 - e1), 32'(SETTLE + 2));
    chk("spacing special", 32'(e3 - e2), 32'd2);
    wait_idle();
    bus.out_ready = 1'b0;

    // Randomized traffic with random consumer stalls
    rnd_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      issue(rnd_op(), rnd_op());
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
